// File: rtl/pulse_scheduler.sv
// pulse_scheduler: round-robin press-to-pulse arbiter with a guard gap after every pulse.
// Define SCHED_DEBOUNCE_EN to add a per-channel stability filter ahead of edge detection.
module pulse_scheduler #(
   parameter int N          = 4,
   parameter int GAP_CYCLES = 3,
   parameter int DEB_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [N-1:0]         btn,
   output logic [N-1:0]         pulse,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 busy,
   output logic [N-1:0]         pending
);
   localparam int GW = $clog2(N);
   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   if (N < 2 || N > 16) begin : g_bad_n
      $error("pulse_scheduler: N out of range");
   end
   if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("pulse_scheduler: GAP_CYCLES out of range");
   end
   if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
      $error("pulse_scheduler: DEB_CYCLES out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  btn_q, btn_d;
   logic [N-1:0]  pending_q, pending_d;
   logic [N-1:0]  pulse_q, pulse_d;
   logic [GW-1:0] grant_id_q, grant_id_d;
   logic [7:0]    gap_q, gap_d;
   logic [N-1:0]  lvl;
   logic [N-1:0]  rise;
   logic [N-1:0]  clr;
   logic          win_found;
   logic [GW-1:0] win_idx;

`ifdef SCHED_DEBOUNCE_EN
   logic [N-1:0]        filt_q, filt_d;
   logic [N-1:0][7:0]   deb_q, deb_d;

   // Filtered level flips only after DEB_CYCLES consecutive disagreeing samples.
   always_comb begin
      filt_d = filt_q;
      deb_d  = '0;
      for (int i = 0; i < N; i++) begin
         if (btn[i] != filt_q[i]) begin
            if (deb_q[i] == 8'(DEB_CYCLES - 1)) begin
               filt_d[i] = btn[i];
            end else begin
               deb_d[i] = deb_q[i] + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= '0;
         deb_q  <= '0;
      end else begin
         filt_q <= filt_d;
         deb_q  <= deb_d;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = btn;
`endif

   assign rise  = lvl & ~btn_q;
   assign btn_d = lvl;

   // Round-robin search starts one past the last served channel.
   always_comb begin
      win_found = 1'b0;
      win_idx   = grant_id_q;
      for (int k = 1; k <= N; k++) begin
         if (!win_found && pending_q[(int'(grant_id_q) + k) % N]) begin
            win_found = 1'b1;
            win_idx   = GW'((int'(grant_id_q) + k) % N);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pulse_d    = '0;
      grant_id_d = grant_id_q;
      gap_d      = gap_q;
      clr        = '0;
      case (state_q)
         S_IDLE: begin
            if (en && win_found) begin
               state_d          = S_ISSUE;
               pulse_d[win_idx] = 1'b1;
               grant_id_d       = win_idx;
               clr[win_idx]     = 1'b1;
            end
         end
         S_ISSUE: begin
            if (GAP_CYCLES == 0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_GAP;
               gap_d   = GAP_LOAD;
            end
         end
         S_GAP: begin
            if (gap_q == 8'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A fresh edge on the grant cycle re-arms the request it would otherwise clear.
   assign pending_d = (pending_q & ~clr) | rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         btn_q      <= '0;
         pending_q  <= '0;
         pulse_q    <= '0;
         grant_id_q <= GW'(N - 1);
         gap_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         btn_q      <= btn_d;
         pending_q  <= pending_d;
         pulse_q    <= pulse_d;
         grant_id_q <= grant_id_d;
         gap_q      <= gap_d;
      end
   end

   assign pulse    = pulse_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q != S_IDLE);
   assign pending  = pending_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Randomized and directed bench for pulse_scheduler against a cycle-level behavioural model.
module tb_pulse_scheduler;
   localparam int N   = 4;
   localparam int GAP = 3;
   localparam int DEB = 4;
`ifdef SCHED_DEBOUNCE_EN
   localparam int LAT = 2 + DEB;
`else
   localparam int LAT = 2;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en  = 1'b0;
   logic [N-1:0] btn = '0;
   logic [N-1:0] pulse;
   logic [1:0]   grant_id;
   logic         busy;
   logic [N-1:0] pending;

   pulse_scheduler #(.N(N), .GAP_CYCLES(GAP), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst(rst), .en(en), .btn(btn),
      .pulse(pulse), .grant_id(grant_id), .busy(busy), .pending(pending)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model state: decisions are allowed only once next_ok is reached.
   logic [N-1:0] m_pend, m_prev, m_pulse, m_filt;
   int           m_ptr, next_ok, last_g;
   int           run [N];
   logic         m_busy;

   int           pulse_cnt;
   int           p_at[$];
   logic [N-1:0] p_val[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_reset();
      m_pend  = '0;
      m_prev  = '0;
      m_pulse = '0;
      m_filt  = '0;
      m_ptr   = N - 1;
      next_ok = 0;
      last_g  = -1000;
      m_busy  = 1'b0;
      for (int i = 0; i < N; i++) run[i] = 0;
   endtask

   task automatic model_edge();
      logic [N-1:0] lvl, ed, clr;
`ifdef SCHED_DEBOUNCE_EN
      lvl = m_filt;
`else
      lvl = btn;
`endif
      ed      = lvl & ~m_prev;
      clr     = '0;
      m_pulse = '0;
      if (en && cyc >= next_ok && m_pend != '0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_pend[c]) begin
               m_ptr = c;
               break;
            end
         end
         clr[m_ptr]     = 1'b1;
         m_pulse[m_ptr] = 1'b1;
         last_g         = cyc;
         next_ok        = cyc + GAP + 2;
      end
      m_busy = (cyc >= last_g) && (cyc <= last_g + GAP);
      m_pend = (m_pend & ~clr) | ed;
      m_prev = lvl;
      for (int i = 0; i < N; i++) begin
         if (btn[i] == m_filt[i]) begin
            run[i] = 0;
         end else begin
            run[i]++;
            if (run[i] == DEB) begin
               m_filt[i] = btn[i];
               run[i]    = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("pulse",    32'(pulse),    32'(m_pulse));
      chk("grant_id", 32'(grant_id), 32'(m_ptr));
      chk("pending",  32'(pending),  32'(m_pend));
      chk("busy",     32'(busy),     32'(m_busy));
      chk("onehot",   32'($onehot0(pulse)), 32'd1);
   endtask

   task automatic clear_log();
      pulse_cnt = 0;
      p_at.delete();
      p_val.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn = '0;
      #1;
      model_reset();
      compare_all();
      #1;
      rst = 1'b0;
      clear_log();
   endtask

   task automatic step(input logic [N-1:0] b, input logic e);
      btn = b;
      en  = e;
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      compare_all();
      if (pulse != '0) begin
         pulse_cnt++;
         p_at.push_back(cyc);
         p_val.push_back(pulse);
      end
   endtask

   initial begin
      int base;
      logic [N-1:0] rb;
      logic         re;

      // Reset state and single held press.
      do_reset();
      base = cyc;
      for (int i = 0; i < 20; i++) step(4'b0100, 1'b1);
      chk("t1_count", 32'(pulse_cnt), 32'd1);
      if (pulse_cnt >= 1) begin
         chk("t1_value", 32'(p_val[0]), 32'h4);
         chk("t1_latency", 32'(p_at[0] - base), 32'(LAT));
      end
      chk("t1_grant", 32'(grant_id), 32'd2);

      // Three simultaneous requests drain in round-robin order.
      do_reset();
      base = cyc;
      for (int i = 0; i < 20; i++) step(4'b1011, 1'b1);
      chk("t2_count", 32'(pulse_cnt), 32'd3);
      if (pulse_cnt == 3) begin
         chk("t2_first", 32'(p_val[0]), 32'h1);
         chk("t2_second", 32'(p_val[1]), 32'h2);
         chk("t2_third", 32'(p_val[2]), 32'h8);
         chk("t2_lat", 32'(p_at[0] - base), 32'(LAT));
         chk("t2_space1", 32'(p_at[1] - p_at[0]), 32'(GAP + 2));
         chk("t2_space2", 32'(p_at[2] - p_at[1]), 32'(GAP + 2));
      end
      chk("t2_drained", 32'(pending), 32'h0);

      // Requests latch while grants are disabled.
      do_reset();
      for (int i = 0; i < 6; i++) step(4'b1010, 1'b0);
      chk("t3_pending", 32'(pending), 32'ha);
      chk("t3_nopulse", 32'(pulse_cnt), 32'd0);
      for (int i = 0; i < 12; i++) step(4'b1010, 1'b1);
      chk("t3_count", 32'(pulse_cnt), 32'd2);
      if (pulse_cnt == 2) begin
         chk("t3_first", 32'(p_val[0]), 32'h2);
         chk("t3_second", 32'(p_val[1]), 32'h8);
         chk("t3_space", 32'(p_at[1] - p_at[0]), 32'(GAP + 2));
      end

      // Re-press lands on the cycle channel 0 is granted.
      do_reset();
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0001, 1'b1);
`ifndef SCHED_DEBOUNCE_EN
      chk("t4_grant_pulse", 32'(pulse), 32'h1);
      chk("t4_kept", 32'(pending[0]), 32'd1);
`endif
      for (int i = 0; i < 8; i++) step(4'b0001, 1'b1);
`ifndef SCHED_DEBOUNCE_EN
      chk("t4_count", 32'(pulse_cnt), 32'd2);
      if (pulse_cnt == 2) chk("t4_space", 32'(p_at[1] - p_at[0]), 32'(GAP + 2));
`endif

      // Reset in the middle of a gap.
      do_reset();
      for (int i = 0; i < LAT + 1; i++) step(4'b0111, 1'b1);
      chk("t5_in_gap", 32'(busy), 32'd1);
      do_reset();
      chk("t5_grant", 32'(grant_id), 32'd3);
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);
      chk("t5_quiet", 32'(pulse_cnt), 32'd0);
      for (int i = 0; i < 10; i++) step(4'b0100, 1'b1);
      chk("t5_fresh", 32'(pulse_cnt), 32'd1);

`ifdef SCHED_DEBOUNCE_EN
      // Short glitch is filtered; a real press arrives DEB cycles late.
      do_reset();
      for (int i = 0; i < 3; i++) step(4'b0010, 1'b1);
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);
      chk("t6_glitch", 32'(pulse_cnt), 32'd0);
      base = cyc;
      for (int i = 0; i < 10; i++) step(4'b0010, 1'b1);
      for (int i = 0; i < 5; i++) step(4'b0000, 1'b1);
      chk("t6_count", 32'(pulse_cnt), 32'd1);
      if (pulse_cnt == 1) chk("t6_latency", 32'(p_at[0] - base), 32'(2 + DEB));
`endif

      // Random traffic with occasional enable drops and asynchronous resets.
      do_reset();
      rb = '0;
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 7) == 0) rb[b] = ~rb[b];
         end
         re = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 299) == 0) do_reset();
         step(rb, re);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
